router_port_arbiter: RTL and testbench
======================================

Name: router_port_arbiter

Overview:
- One instance per router output port; grants the output to one of N_PORTS input ports whose decoded destination address targets it.
- Round-robin fairness; holds the grant for a whole packet (frame); enforces an inter-packet gap and a packet-length watchdog.
- Sits between the per-input address decoders and the output crossbar mux. grant drives the mux select; blocked feeds the busy_n logic (busy_n = ~blocked at the top level).

Parameters:
- N_PORTS, 16, number of input requesters.
- MAX_PKT_CYCLES, 64, watchdog limit in cycles of grant before forced release; legal range is 2 or more.
- GAP_CYCLES, 1, idle cycles between packets on the output; legal range is 1 or more.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  N_PORTS  req[i]=1: input i has a frame addressed to this output; held high through the frame
- eop  in  N_PORTS  eop[i]=1 for one cycle on the last payload bit of input i's frame
- grant  out  N_PORTS  one-hot or zero; registered
- grant_id  out  $clog2(N_PORTS)  index of the granted input; valid while active=1
- active  out  1  1 while in state GRANT
- blocked  out  N_PORTS  req & ~grant (combinational)
- timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset values:
  - grant=0, grant_id=0, active=0, timeout=0.
  - Round-robin pointer ptr=0, state IDLE, counters 0.
  - blocked follows req while reset is asserted.
- States:
  - IDLE: if |req, winner = first i with req[i]=1 searching circularly from ptr (ptr, ptr+1 … wrapping). Next edge: grant=onehot(winner), grant_id=winner, active=1, pkt_cnt=0, go to GRANT. Latency is exactly 1 cycle from req to grant.
  - GRANT: pkt_cnt increments each cycle, saturating at MAX_PKT_CYCLES-1. The release condition is evaluated on the current cycle's inputs. Release when any of:
    - eop[grant_id]=1 (normal end);
    - req[grant_id]=0 (abort);
    - pkt_cnt==MAX_PKT_CYCLES-1 (watchdog; timeout=1 for exactly the next cycle).
  - On release (next edge): grant=0, active=0, ptr=(grant_id+1) mod N_PORTS, gap_cnt=0, go to GAP.
  - GAP: grant stays 0 for GAP_CYCLES cycles, then IDLE. Requests are ignored during GAP.
- Priority and boundary rules:
  - eop and watchdog in the same cycle: treat as a normal end; no timeout pulse.
  - eop on non-granted inputs is ignored. eop in IDLE or GAP is ignored.
  - Requester changes during GRANT have no effect on grant (no preemption).
  - ptr wrap: grant_id=N_PORTS-1 gives ptr=0.
  - Single requester re-requesting keeps winning after each GAP.
  - All N_PORTS requesting: each is served once per N_PORTS packets, in ascending circular order.
  - Reset asserted mid-GRANT: grant drops asynchronously the same instant. The packet is lost; no timeout pulse.
- Invariants:
  - grant is never multi-hot.
  - There are at least GAP_CYCLES cycles with grant=0 between any two grants.

Decomposition:
- router_pkg holds:
  - N_PORTS_DEFAULT=16;
  - typedef port_id_t logic[3:0];
  - enum arb_state_t {ARB_IDLE, ARB_GRANT, ARB_GAP}.
- Sub-module rr_pick: combinational circular priority encoder.
  - Inputs: req, ptr.
  - Outputs: found, idx.
  - Implemented by the double-width masked-request method.
  - Unit-tested standalone.

Test Plan:
- Reset, then req=16'h0402 (inputs 1,10) held; eop[1] pulses at grant cycle+20 -> grant=16'h0002 one cycle after req. Then GAP 1 cycle, then grant=16'h0400, ptr=11 after its eop.
- ptr=15 with req=16'h8001 -> grant_id=15 first, then 0 (wrap). blocked=16'h0001 during the first grant.
- Single requester 3, eop never asserted, MAX_PKT_CYCLES=64 -> release after 64 grant cycles, timeout pulse of 1 cycle. GRANT is re-entered for 3 after GAP.
- req[4] dropped mid-packet (abort) while req[9] pending -> grant 4 released next edge, no timeout, grant=16'h0200 after GAP.
- eop[grant_id] on the same cycle pkt_cnt hits the limit -> normal release, timeout stays 0. eop on a non-granted input changes nothing.
- reset asserted asynchronously mid-GRANT (between edges) -> grant=0, active=0 immediately. After deassert with req=16'hFFFF, the first grant is to input 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types for the router output-port arbiter.
package router_pkg;

   localparam int N_PORTS_DEFAULT = 16;

   typedef logic [3:0] port_id_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_GAP
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority encoder: lowest set request at or after ptr,
// wrapping, found by masking the low copy of a doubled request vector.
module rr_pick #(
   parameter int N  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] mask;
   logic [2*N-1:0] masked;

   always_comb begin
      dbl    = {req_i, req_i};
      // Clears bits below ptr in the low copy; the high copy supplies the wrap.
      mask   = ~(((2*N)'(1) << ptr_i) - (2*N)'(1));
      masked = dbl & mask;
      idx_o  = '0;
      for (int j = 2*N-1; j >= 0; j--) begin
         if (masked[j]) idx_o = (j >= N) ? IW'(j - N) : IW'(j);
      end
   end

   assign found_o = |req_i;

endmodule

// File: rtl/router_port_arbiter.sv
// Per-output-port round-robin arbiter: holds grant for a whole frame, inserts an
// inter-packet gap and force-releases a grant that exceeds the length watchdog.
module router_port_arbiter
   import router_pkg::*;
#(
   parameter int N_PORTS        = N_PORTS_DEFAULT,
   parameter int MAX_PKT_CYCLES = 64,
   parameter int GAP_CYCLES     = 1,
   localparam int IW            = $clog2(N_PORTS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_PORTS-1:0] req,
   input  logic [N_PORTS-1:0] eop,
   output logic [N_PORTS-1:0] grant,
   output logic [IW-1:0]      grant_id,
   output logic               active,
   output logic [N_PORTS-1:0] blocked,
   output logic               timeout
);

   localparam int CW = $clog2(MAX_PKT_CYCLES);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] PKT_LAST = CW'(MAX_PKT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] ID_LAST  = IW'(N_PORTS - 1);

   arb_state_t         state_q, state_d;
   logic [N_PORTS-1:0] grant_q, grant_d;
   logic [IW-1:0]      gid_q, gid_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [CW-1:0]      pkt_cnt_q, pkt_cnt_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
   logic               timeout_q, timeout_d;

   logic               pick_found;
   logic [IW-1:0]      pick_idx;
   logic               rel_eop, rel_abort, rel_wd;

   rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign rel_eop   = eop[gid_q];
   assign rel_abort = ~req[gid_q];
   assign rel_wd    = (pkt_cnt_q == PKT_LAST);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gid_d     = gid_q;
      ptr_d     = ptr_q;
      pkt_cnt_d = pkt_cnt_q;
      gap_cnt_d = gap_cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d           = ARB_GRANT;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               gid_d             = pick_idx;
               pkt_cnt_d         = '0;
            end
         end
         ARB_GRANT: begin
            if (pkt_cnt_q != PKT_LAST) pkt_cnt_d = pkt_cnt_q + 1'b1;
            if (rel_eop || rel_abort || rel_wd) begin
               state_d   = ARB_GAP;
               grant_d   = '0;
               ptr_d     = (gid_q == ID_LAST) ? '0 : gid_q + 1'b1;
               gap_cnt_d = '0;
               // A frame ending exactly at the limit is a normal end.
               timeout_d = rel_wd & ~rel_eop;
            end
         end
         ARB_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = ARB_IDLE;
            else                       gap_cnt_d = gap_cnt_q + 1'b1;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ARB_IDLE;
         grant_q   <= '0;
         gid_q     <= '0;
         ptr_q     <= '0;
         pkt_cnt_q <= '0;
         gap_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gid_q     <= gid_d;
         ptr_q     <= ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = gid_q;
   assign active   = (state_q == ARB_GRANT);
   assign timeout  = timeout_q;
   assign blocked  = req & ~grant_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed scoreboard bench for router_port_arbiter (16 ports, 64-cycle watchdog, 1-cycle gap).
module tb_router_port_arbiter;
   import router_pkg::*;

   localparam int N = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req, eop, grant, blocked;
   logic [3:0]    grant_id;
   logic          active, timeout;

   int            checks   = 0;
   int            failures = 0;
   port_id_t      exp_q[$];
   port_id_t      to_q[$];

   router_port_arbiter #(.N_PORTS(N), .MAX_PKT_CYCLES(64), .GAP_CYCLES(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .eop      (eop),
      .grant    (grant),
      .grant_id (grant_id),
      .active   (active),
      .blocked  (blocked),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_active();
      int n = 0;
      while (!active && n < 20) begin
         tick();
         n++;
      end
      chk("wait_active", {31'd0, active}, 32'd1);
   endtask

   // Hold the current grant n cycles, pulse its eop, then move req to nxt.
   task automatic serve(input int id, input int n, input logic [N-1:0] nxt);
      repeat (n) tick();
      eop = '0;
      eop[id] = 1'b1;
      tick();
      eop = '0;
      req = nxt;
   endtask

   // Pops an expected winner on each new grant and an expected owner on each timeout pulse.
   task automatic monitor();
      logic [N-1:0] prev = '0;
      port_id_t     last_id = '0;
      int           zero_run = 100;
      port_id_t     e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = '0;
         end else begin
            chk("onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            if (grant != '0 && prev == '0) begin
               chk("gap_len", {31'd0, (zero_run >= 1)}, 32'd1);
               if (exp_q.size() == 0) begin
                  chk("unexpected_grant", {28'd0, grant_id}, 32'hFFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("grant_id", {28'd0, grant_id}, {28'd0, e});
                  chk("grant_vec", {16'd0, grant}, 32'd1 << e);
               end
               last_id = grant_id;
            end
            if (timeout) begin
               if (to_q.size() == 0) begin
                  chk("unexpected_timeout", 32'd1, 32'd0);
               end else begin
                  e = to_q.pop_front();
                  chk("timeout_owner", {28'd0, last_id}, {28'd0, e});
               end
            end
            zero_run = (grant == '0) ? zero_run + 1 : 0;
            prev = grant;
         end
      end
   endtask

   initial begin
      int cnt;
      fork
         monitor();
      join_none
      reset = 1'b1;
      req   = 16'h00F0;
      eop   = '0;
      #2;
      chk("rst_grant", {16'd0, grant}, 32'd0);
      chk("rst_grant_id", {28'd0, grant_id}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_blocked", {16'd0, blocked}, 32'h00F0);
      req = '0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Inputs 1 and 10: 1 first (ptr 0), 10 after the gap, then 11 proves ptr=11.
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd10);
      req = 16'h0402;
      tick();
      chk("latency_1", {16'd0, grant}, 32'h0002);
      serve(1, 20, 16'h0402);
      wait_active();
      exp_q.push_back(4'd11);
      req = 16'h0C02;
      serve(10, 5, 16'h0C02);
      wait_active();

      // Reach ptr=15 via input 14, then 15 and the wrap to 0.
      exp_q.push_back(4'd14);
      serve(11, 3, 16'h4000);
      wait_active();
      exp_q.push_back(4'd15);
      exp_q.push_back(4'd0);
      serve(14, 2, 16'h8001);
      wait_active();
      chk("blocked_wrap", {16'd0, blocked}, 32'h0001);
      serve(15, 4, 16'h8001);
      wait_active();

      // Lone requester 3 without eop: watchdog after 64 grant cycles, then re-grant.
      exp_q.push_back(4'd3);
      exp_q.push_back(4'd3);
      to_q.push_back(4'd3);
      serve(0, 2, 16'h0008);
      wait_active();
      cnt = 0;
      while (active && cnt < 100) begin
         cnt++;
         tick();
      end
      chk("wd_cycles", cnt, 32'd64);
      chk("timeout_pulse", {31'd0, timeout}, 32'd1);
      tick();
      chk("timeout_one_cycle", {31'd0, timeout}, 32'd0);
      wait_active();

      // Abort: 4 drops req mid-frame while 9 waits.
      exp_q.push_back(4'd4);
      exp_q.push_back(4'd9);
      serve(3, 2, 16'h0210);
      wait_active();
      repeat (5) tick();
      req = 16'h0200;
      tick();
      chk("abort_active", {31'd0, active}, 32'd0);
      chk("abort_grant", {16'd0, grant}, 32'd0);
      chk("abort_timeout", {31'd0, timeout}, 32'd0);
      wait_active();

      // 9: stray eop on input 5, then its own eop exactly at the watchdog limit.
      for (int k = 1; k <= 63; k++) begin
         tick();
         eop = (k == 10) ? 16'h0020 : (k == 63) ? 16'h0200 : 16'h0000;
         if (k == 11) chk("stray_eop", {16'd0, grant}, 32'h0200);
      end
      tick();
      eop = '0;
      req = '0;
      chk("eop_wd_active", {31'd0, active}, 32'd0);
      chk("eop_wd_timeout", {31'd0, timeout}, 32'd0);
      repeat (3) tick();

      // Async reset mid-frame, then all request and input 0 wins.
      exp_q.push_back(4'd10);
      req = 16'hFFFF;
      wait_active();
      repeat (3) tick();
      #3;
      reset = 1'b1;
      #1;
      chk("async_grant", {16'd0, grant}, 32'd0);
      chk("async_active", {31'd0, active}, 32'd0);
      chk("async_blocked", {16'd0, blocked}, 32'hFFFF);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.push_back(4'd0);
      wait_active();
      serve(0, 3, 16'h0000);
      repeat (5) tick();

      chk("exp_q_empty", exp_q.size(), 32'd0);
      chk("to_q_empty", to_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
